// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: one buffered entry each for the ALU and load paths, oldest first.
// Optional WB_PENDING_EN macro adds a registered bitmap of registers with buffered writes.
module reg_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          ExReq,
  input  logic [AW-1:0] ExAddr,
  input  logic [DW-1:0] ExData,
  output logic          ExAck,
  input  logic          MemReq,
  input  logic [AW-1:0] MemAddr,
  input  logic [DW-1:0] MemData,
  output logic          MemAck,
  output logic          RegWrite,
  output logic [AW-1:0] RdAddr,
  output logic [DW-1:0] RdData,
  output logic [31:0]   Pending
);

  logic          ex_vld_q, ex_vld_d, mem_vld_q, mem_vld_d;
  logic [AW-1:0] ex_addr_q, ex_addr_d, mem_addr_q, mem_addr_d;
  logic [DW-1:0] ex_data_q, ex_data_d, mem_data_q, mem_data_d;
  logic          ex_older_q, ex_older_d;
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] rdaddr_q, rdaddr_d;
  logic [DW-1:0] rddata_q, rddata_d;
  logic          grant_ex, grant_mem, ex_load, mem_load, ex_keep, mem_keep;

  always_comb begin
    // ex_older_q set means the Ex entry was accepted strictly before the Mem entry.
    grant_mem  = mem_vld_q & (~ex_vld_q | ~ex_older_q);
    grant_ex   = ex_vld_q & (~mem_vld_q | ex_older_q);

    // Writes to r0 are acknowledged and dropped, independent of buffer occupancy.
    ExAck      = nReset & ExReq & ((ExAddr == '0) | ~ex_vld_q | grant_ex);
    MemAck     = nReset & MemReq & ((MemAddr == '0) | ~mem_vld_q | grant_mem);
    ex_load    = ExAck & (ExAddr != '0);
    mem_load   = MemAck & (MemAddr != '0);
    ex_keep    = ex_vld_q & ~grant_ex;
    mem_keep   = mem_vld_q & ~grant_mem;

    ex_vld_d   = ex_load | ex_keep;
    mem_vld_d  = mem_load | mem_keep;
    ex_addr_d  = ex_load ? ExAddr : ex_addr_q;
    ex_data_d  = ex_load ? ExData : ex_data_q;
    mem_addr_d = mem_load ? MemAddr : mem_addr_q;
    mem_data_d = mem_load ? MemData : mem_data_q;

    // A same-cycle pair leaves the bit clear, so Mem wins the tie.
    ex_older_d = ex_keep & (mem_load | ex_older_q);

    regwrite_d = grant_ex | grant_mem;
    rdaddr_d   = rdaddr_q;
    rddata_d   = rddata_q;
    if (grant_mem) begin
      rdaddr_d = mem_addr_q;
      rddata_d = mem_data_q;
    end else if (grant_ex) begin
      rdaddr_d = ex_addr_q;
      rddata_d = ex_data_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      ex_vld_q   <= 1'b0;
      mem_vld_q  <= 1'b0;
      ex_older_q <= 1'b0;
      regwrite_q <= 1'b0;
      rdaddr_q   <= '0;
      rddata_q   <= '0;
    end else begin
      ex_vld_q   <= ex_vld_d;
      mem_vld_q  <= mem_vld_d;
      ex_older_q <= ex_older_d;
      regwrite_q <= regwrite_d;
      rdaddr_q   <= rdaddr_d;
      rddata_q   <= rddata_d;
    end
  end

  always_ff @(posedge Clock) begin
    ex_addr_q  <= ex_addr_d;
    ex_data_q  <= ex_data_d;
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

  assign RegWrite = regwrite_q;
  assign RdAddr   = rdaddr_q;
  assign RdData   = rddata_q;

`ifdef WB_PENDING_EN
  logic [31:0] pend_q, pend_d;

  always_comb begin
    pend_d = '0;
    for (int i = 1; i < 32; i++) begin
      pend_d[i] = (ex_vld_d && (32'(ex_addr_d) == 32'(i))) ||
                  (mem_vld_d && (32'(mem_addr_d) == 32'(i)));
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign Pending = pend_q;
`else
  assign Pending = 32'd0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Testbench for reg_wb_arbiter: directed scenarios plus randomized traffic against a timestamp-ordered model.
module tb_reg_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          Clock = 1'b0;
  logic          nReset, ExReq, MemReq;
  logic [AW-1:0] ExAddr, MemAddr;
  logic [DW-1:0] ExData, MemData;
  logic          ExAck, MemAck, RegWrite;
  logic [AW-1:0] RdAddr;
  logic [DW-1:0] RdData;
  logic [31:0]   Pending;

  int vectors = 0;
  int miscompares = 0;

  reg_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .Clock(Clock), .nReset(nReset),
    .ExReq(ExReq), .ExAddr(ExAddr), .ExData(ExData), .ExAck(ExAck),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemData(MemData), .MemAck(MemAck),
    .RegWrite(RegWrite), .RdAddr(RdAddr), .RdData(RdData), .Pending(Pending)
  );

  always #5 Clock = ~Clock;

  // Reference model: each buffered entry carries the cycle it was accepted in.
  bit          m_ev, m_mv, m_we;
  logic [4:0]  m_ea, m_ma, m_ra;
  logic [31:0] m_ed, m_md, m_rd, m_pend;
  int          m_et, m_mt, cyc;
  logic [31:0] obs_rf [32];

  function automatic bit gm();
    return m_mv && (!m_ev || m_mt <= m_et);
  endfunction

  function automatic bit ge();
    return m_ev && (!m_mv || m_et < m_mt);
  endfunction

  function automatic bit exp_eack();
    return nReset && ExReq && (ExAddr == 0 || !m_ev || ge());
  endfunction

  function automatic bit exp_mack();
    return nReset && MemReq && (MemAddr == 0 || !m_mv || gm());
  endfunction

  function automatic logic [31:0] pend_of(input logic [4:0] a);
    logic [31:0] p;
    p = 32'd0;
`ifdef WB_PENDING_EN
    p[a] = 1'b1;
`endif
    return p;
  endfunction

  task automatic tick();
    bit g_m, g_e, ea, ma;
    g_m = gm(); g_e = ge(); ea = exp_eack(); ma = exp_mack();
    @(posedge Clock);
    if (!nReset) begin
      m_ev = 0; m_mv = 0; m_we = 0; m_ra = '0; m_rd = '0;
    end else begin
      m_we = g_m || g_e;
      if (g_m) begin m_ra = m_ma; m_rd = m_md; m_mv = 0; end
      else if (g_e) begin m_ra = m_ea; m_rd = m_ed; m_ev = 0; end
      if (ea && ExAddr != 0) begin m_ev = 1; m_ea = ExAddr; m_ed = ExData; m_et = cyc; end
      if (ma && MemAddr != 0) begin m_mv = 1; m_ma = MemAddr; m_md = MemData; m_mt = cyc; end
    end
    cyc++;
    m_pend = 32'd0;
`ifdef WB_PENDING_EN
    if (m_ev) m_pend[m_ea] = 1'b1;
    if (m_mv) m_pend[m_ma] = 1'b1;
`endif
    #1;
    if (RegWrite === 1'b1) obs_rf[RdAddr] = RdData;
  endtask

  task automatic idle();
    ExReq = 0; MemReq = 0; ExAddr = '0; MemAddr = '0; ExData = '0; MemData = '0;
  endtask

  task automatic test_reset();
    nReset = 0; ExReq = 1; ExAddr = 5'd3; MemReq = 1; MemAddr = 5'd4;
    #1;
    vectors++; if (ExAck !== 1'b0) begin miscompares++; $display("FAIL rst_exack got %b want 0", ExAck); end
    vectors++; if (MemAck !== 1'b0) begin miscompares++; $display("FAIL rst_memack got %b want 0", MemAck); end
    tick(); tick();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL rst_regwrite got %b want 0", RegWrite); end
    vectors++; if (RdAddr !== 5'd0) begin miscompares++; $display("FAIL rst_rdaddr got %h want 0", RdAddr); end
    vectors++; if (RdData !== 32'd0) begin miscompares++; $display("FAIL rst_rddata got %h want 0", RdData); end
    vectors++; if (Pending !== 32'd0) begin miscompares++; $display("FAIL rst_pending got %h want 0", Pending); end
    idle(); nReset = 1;
    tick();
  endtask

  task automatic test_single();
    ExReq = 1; ExAddr = 5'd5; ExData = 32'hDEAD_BEEF;
    #1;
    vectors++; if (ExAck !== 1'b1) begin miscompares++; $display("FAIL single_ack got %b want 1", ExAck); end
    tick(); idle();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL single_buffered got %b want 0", RegWrite); end
    vectors++; if (Pending !== pend_of(5'd5)) begin miscompares++; $display("FAIL single_pending got %h want %h", Pending, pend_of(5'd5)); end
    tick();
    vectors++; if ({RegWrite, RdAddr, RdData} !== {1'b1, 5'd5, 32'hDEAD_BEEF})
      begin miscompares++; $display("FAIL single_write got %b/%0d/%h want 1/5/deadbeef", RegWrite, RdAddr, RdData); end
    tick();
    vectors++; if ({RegWrite, RdAddr, RdData} !== {1'b0, 5'd5, 32'hDEAD_BEEF})
      begin miscompares++; $display("FAIL single_hold got %b/%0d/%h want 0/5/deadbeef", RegWrite, RdAddr, RdData); end
  endtask

  task automatic test_same_cycle();
    ExReq = 1; ExAddr = 5'd3; ExData = 32'h11; MemReq = 1; MemAddr = 5'd4; MemData = 32'h22;
    #1;
    vectors++; if ({ExAck, MemAck} !== 2'b11) begin miscompares++; $display("FAIL same_acks got %b want 11", {ExAck, MemAck}); end
    tick(); idle(); tick();
    vectors++; if ({RegWrite, RdAddr, RdData} !== {1'b1, 5'd4, 32'h22})
      begin miscompares++; $display("FAIL same_first got %b/%0d/%h want 1/4/22", RegWrite, RdAddr, RdData); end
    tick();
    vectors++; if ({RegWrite, RdAddr, RdData} !== {1'b1, 5'd3, 32'h11})
      begin miscompares++; $display("FAIL same_second got %b/%0d/%h want 1/3/11", RegWrite, RdAddr, RdData); end
    tick();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL same_done got %b want 0", RegWrite); end
  endtask

  task automatic test_order();
    MemReq = 1; MemAddr = 5'd7; MemData = 32'hAA;
    tick();
    MemData = 32'hCC; ExReq = 1; ExAddr = 5'd7; ExData = 32'hBB;
    #1;
    vectors++; if ({ExAck, MemAck} !== 2'b11) begin miscompares++; $display("FAIL order_acks got %b want 11", {ExAck, MemAck}); end
    tick(); idle();
    vectors++; if ({RegWrite, RdAddr, RdData} !== {1'b1, 5'd7, 32'hAA})
      begin miscompares++; $display("FAIL order_first got %b/%0d/%h want 1/7/aa", RegWrite, RdAddr, RdData); end
    tick();
    vectors++; if ({RegWrite, RdAddr, RdData} !== {1'b1, 5'd7, 32'hCC})
      begin miscompares++; $display("FAIL order_mid got %b/%0d/%h want 1/7/cc", RegWrite, RdAddr, RdData); end
    tick();
    vectors++; if ({RegWrite, RdAddr, RdData} !== {1'b1, 5'd7, 32'hBB})
      begin miscompares++; $display("FAIL order_last got %b/%0d/%h want 1/7/bb", RegWrite, RdAddr, RdData); end
    tick();
    vectors++; if (obs_rf[7] !== 32'hBB) begin miscompares++; $display("FAIL order_final got %h want bb", obs_rf[7]); end
  endtask

  task automatic test_zero_addr();
    ExReq = 1; ExAddr = 5'd0; ExData = 32'hFFFF_FFFF;
    #1;
    vectors++; if (ExAck !== 1'b1) begin miscompares++; $display("FAIL zero_ack got %b want 1", ExAck); end
    tick(); idle();
    vectors++; if (Pending[0] !== 1'b0 || Pending !== 32'd0) begin miscompares++; $display("FAIL zero_pending got %h want 0", Pending); end
    tick();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL zero_nowrite got %b want 0", RegWrite); end
  endtask

  task automatic test_backpressure();
    MemReq = 1; MemAddr = 5'd1; MemData = 32'h101;
    tick();
    MemAddr = 5'd6; MemData = 32'h606; ExReq = 1; ExAddr = 5'd2; ExData = 32'h202;
    tick();
    MemReq = 0; ExAddr = 5'd8; ExData = 32'h808;
    #1;
    vectors++; if (ExAck !== 1'b0) begin miscompares++; $display("FAIL bp_exack_blocked got %b want 0", ExAck); end
    ExAddr = 5'd0;
    #1;
    vectors++; if (ExAck !== 1'b1) begin miscompares++; $display("FAIL bp_exack_r0 got %b want 1", ExAck); end
    tick(); idle();
    vectors++; if ({RegWrite, RdAddr, RdData} !== {1'b1, 5'd6, 32'h606})
      begin miscompares++; $display("FAIL bp_mem got %b/%0d/%h want 1/6/606", RegWrite, RdAddr, RdData); end
    tick();
    vectors++; if ({RegWrite, RdAddr, RdData} !== {1'b1, 5'd2, 32'h202})
      begin miscompares++; $display("FAIL bp_ex got %b/%0d/%h want 1/2/202", RegWrite, RdAddr, RdData); end
    tick();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL bp_done got %b want 0", RegWrite); end
  endtask

  task automatic test_reset_mid();
    MemReq = 1; MemAddr = 5'd1; MemData = 32'h1;
    tick();
    MemAddr = 5'd6; MemData = 32'h6; ExReq = 1; ExAddr = 5'd2; ExData = 32'h2;
    tick();
    nReset = 0;
    #1;
    vectors++; if ({ExAck, MemAck} !== 2'b00) begin miscompares++; $display("FAIL rmid_acks got %b want 00", {ExAck, MemAck}); end
    tick();
    vectors++; if ({RegWrite, RdAddr, RdData, Pending} !== {1'b0, 5'd0, 32'd0, 32'd0})
      begin miscompares++; $display("FAIL rmid_state got %b/%0d/%h/%h want 0/0/0/0", RegWrite, RdAddr, RdData, Pending); end
    nReset = 1; idle();
    tick();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL rmid_stale1 got %b want 0", RegWrite); end
    tick();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL rmid_stale2 got %b want 0", RegWrite); end
  endtask

  task automatic test_pending();
    MemReq = 1; MemAddr = 5'd9; MemData = 32'h99;
    tick(); idle();
    vectors++; if (Pending !== pend_of(5'd9)) begin miscompares++; $display("FAIL pend_set got %h want %h", Pending, pend_of(5'd9)); end
    tick();
    vectors++; if (RegWrite !== 1'b1 || Pending !== 32'd0)
      begin miscompares++; $display("FAIL pend_clear got %b/%h want 1/0", RegWrite, Pending); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      nReset  = ($urandom_range(0, 49) != 0);
      ExReq   = 1'($urandom_range(0, 1));
      ExAddr  = 5'($urandom_range(0, 7));
      ExData  = $urandom;
      MemReq  = 1'($urandom_range(0, 1));
      MemAddr = 5'($urandom_range(0, 7));
      MemData = $urandom;
      #1;
      vectors++; if (ExAck !== exp_eack()) begin miscompares++; $display("FAIL rnd_exack cyc %0d got %b want %b", cyc, ExAck, exp_eack()); end
      vectors++; if (MemAck !== exp_mack()) begin miscompares++; $display("FAIL rnd_memack cyc %0d got %b want %b", cyc, MemAck, exp_mack()); end
      tick();
      vectors++; if ({RegWrite, RdAddr, RdData} !== {m_we, m_ra, m_rd})
        begin miscompares++; $display("FAIL rnd_write cyc %0d got %b/%0d/%h want %b/%0d/%h", cyc, RegWrite, RdAddr, RdData, m_we, m_ra, m_rd); end
      vectors++; if (Pending !== m_pend) begin miscompares++; $display("FAIL rnd_pending cyc %0d got %h want %h", cyc, Pending, m_pend); end
    end
    nReset = 1; idle();
    tick(); tick(); tick();
  endtask

  initial begin
    cyc = 0; m_ev = 0; m_mv = 0; m_we = 0; m_ra = '0; m_rd = '0; m_pend = '0;
    m_ea = '0; m_ma = '0; m_ed = '0; m_md = '0; m_et = 0; m_mt = 0;
    for (int i = 0; i < 32; i++) obs_rf[i] = '0;
    idle();
    test_reset();
    test_single();
    test_same_cycle();
    test_order();
    test_zero_addr();
    test_backpressure();
    test_reset_mid();
    test_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, register data width.
REQ-002 SHALL have parameter AW, default 5, register address width (32 registers).
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port nReset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ExReq  input  1  ALU writeback request.
REQ-006 SHALL have port ExAddr  input  AW  ALU destination register.
REQ-007 SHALL have port ExData  input  DW  ALU result.
REQ-008 SHALL have port ExAck  output  1  ALU request accepted this cycle (combinational).
REQ-009 SHALL have port MemReq  input  1  load/multicycle-unit writeback request.
REQ-010 SHALL have port MemAddr  input  AW  load destination register.
REQ-011 SHALL have port MemData  input  DW  load data.
REQ-012 SHALL have port MemAck  output  1  load request accepted this cycle (combinational).
REQ-013 SHALL have port RegWrite  output  1  registered write strobe to register file.
REQ-014 SHALL have port RdAddr  output  AW  registered write address.
REQ-015 SHALL have port RdData  output  DW  registered write data.
REQ-016 SHALL have port Pending  output  32  bitmap of registers with buffered, unissued writes.

Function
REQ-017 SHALL hold one buffer entry per source (valid, addr, data); one write issued per cycle max.
REQ-018 SHALL assert XAck = XReq & (X buffer empty | X entry granted this cycle).
REQ-019 SHALL, on XReq & XAck with XAddr != 0, load X buffer next edge.
REQ-020 SHALL, on XReq with XAddr == 0, assert XAck regardless of buffer state, buffer nothing, issue no write.
REQ-021 SHALL grant, when exactly one buffer valid, that entry.
REQ-022 SHALL grant, when both valid, the entry accepted in the earlier cycle (age bit).
REQ-023 SHALL grant Mem first when both entries were accepted in the same cycle.
REQ-024 SHALL register the granted entry: RegWrite=1, RdAddr, RdData on the edge after grant; RegWrite=0 cycles with no grant.
REQ-025 SHALL give latency: request accepted edge N, buffered after N, RegWrite high after N+1 when uncontended.
REQ-026 SHALL clear a granted buffer and accept a new request on the same edge (full throughput, no bubble).
REQ-027 SHALL, with both buffers full and Mem older, issue Mem, then Ex on consecutive cycles; ExAck=0 while Ex buffered and not granted.
REQ-028 SHALL preserve per-address program order: two writes to the same register issue in acceptance order.
REQ-029 SHALL hold RdAddr/RdData stable when RegWrite=0 (last issued values).

Reset
REQ-030 SHALL, when nReset=0 at a rising edge, clear both buffers, age bit, RegWrite=0, RdAddr=0, RdData=0, Pending=0.
REQ-031 SHALL discard buffered entries on reset mid-operation; no write issued in the cycle after reset.
REQ-032 SHALL force ExAck=0 and MemAck=0 while nReset=0.

Configuration
REQ-033 SHALL, with WB_PENDING_EN defined, drive Pending[i]=1 iff a valid buffer holds address i, registered with buffers; Pending[0] always 0.
REQ-034 SHALL, without WB_PENDING_EN, tie Pending to 32'd0 and contain no pending logic.

Verification
REQ-035 SHALL test: ExReq, ExAddr=5, ExData=32'hDEAD_BEEF at edge N, idle Mem -> ExAck=1; RegWrite=1, RdAddr=5, RdData=32'hDEAD_BEEF after N+1; RegWrite=0 after N+2.
REQ-036 SHALL test: same cycle ExReq(3,32'h11) and MemReq(4,32'h22) -> both Acks=1; writes issue Mem(4,32'h22) then Ex(3,32'h11) on consecutive cycles.
REQ-037 SHALL test: MemReq(7,32'hAA) cycle N, then both Req(7) cycle N+1, Ex data 32'hBB -> issue order 7/32'hAA then 7/32'hBB; final register value 32'hBB.
REQ-038 SHALL test: ExReq with ExAddr=0, ExData=32'hFFFF_FFFF -> ExAck=1, RegWrite stays 0, Pending[0]=0.
REQ-039 SHALL test: both buffers full, nReset=0 one edge -> RegWrite=0, RdAddr=0, RdData=0, Pending=0, Acks=0; no stale write after release.
REQ-040 SHALL test (WB_PENDING_EN): MemReq(9) accepted -> Pending=32'h200 until edge issuing write, then 0; without macro Pending=0 throughout.
